cs2fifoc: RTL
=============

// Module: cs2fifoc
// PURPOSE
//  Command-frame transmitter; the write-side mirror of the fifoc command parser.
//  On an fs request it snapshots nine command registers, then writes one frame into the command FIFO:
//  0x55, 0xAA, 9 payload bytes, 1 checksum byte.
//  Sits between the control/config logic and the FIFO that feeds the remote receiver; fs/fd handshake as elsewhere.
// PARAMETERS
//  HEAD0   8'h55    first header byte
//  HEAD1   8'hAA    second header byte
//  TO_W    16       width of stall timeout counter
//  TIMEOUT 16'd1000 consecutive fifoc_full cycles in one state before error
// PORTS
//  clk        in  1  system clock, all logic on rising edge
//  rst        in  1  asynchronous reset, ACTIVE-LOW (rst==0 resets)
//  err        out 1  sticky error: FIFO stall timeout
//  fs         in  1  frame start request (level)
//  fd         out 1  frame done, =1 while state==LAST
//  so         out 8  current state code (debug)
//  fifoc_full in  1  FIFO programmable-full: 1 when <2 free entries
//  fifoc_txen out 1  FIFO write enable (registered)
//  fifoc_txd  out 8  FIFO write data (registered)
//  kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1
//             in  8 each  payload bytes, sent in this order
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, fifoc_txen=0, fifoc_txd=0, err=0, check=0, snapshot regs=0, stall cnt=0.
//  State codes (so): IDLE 00, HED0 03, HED1 04, CMD0..CMD8 05..0D, PART 0E, LAST 0F, ERR 11.
//  IDLE: fs=1 at an edge -> snapshot all 9 payload inputs, check<=0, go HED0. fs=0 -> stay.
//  Emit states HED0,HED1,CMD0..CMD8,PART, one byte each:
//   - fifoc_full=0 at edge: txen<=1, txd<=byte, advance to next state, stall cnt<=0.
//   - fifoc_full=1 at edge: txen<=0, txd holds, state holds, stall cnt+1.
//   - HED0 sends HEAD0; HED1 sends HEAD1; CMDn sends snapshot byte n.
//   - check: CMD0 loads byte, CMD1..CMD8 add byte, 8-bit wrap (mod 256).
//   - PART sends check; then goes LAST.
//   - Header bytes are not summed.
//  Latency: with fifoc_full=0, first write 1 cycle after fs is sampled. 12 back-to-back txen cycles.
//   fd rises on the same cycle txen carries the checksum.
//  LAST: txen<=0. fd=1. fs=0 at edge -> IDLE. fs held high -> stay LAST; no repeat frame.
//  fs in any state other than IDLE/LAST: ignored. Snapshot inputs may change freely after capture.
//  Timeout: stall cnt reaches TIMEOUT -> ERR. err=1, txen=0. ERR is exited only by reset.
//  Reset mid-frame: bytes already written stay in FIFO (no retraction); block returns to IDLE.
//  Each byte is written exactly once: no drops or duplicates across any stall pattern.
//  Simultaneous full rise and state advance: the registered write issued before full rose is valid.
//   The FIFO full margin of 2 entries guarantees this.
// TESTING
//  1 Payload 01..09, full=0, pulse fs -> txd seq 55 AA 01 02 03 04 05 06 07 08 09 2D.
//    12 consecutive txen; fd=1 with the 2D write.
//  2 Payload all FF -> checksum byte F7 (2295 mod 256); frame otherwise as in 1.
//  3 full=1 for 5 cycles while in CMD3 -> txen=0 for 5 cycles, then 04 written once.
//    Still 12 writes total, same byte sequence.
//  4 TIMEOUT=8, full held 1 from HED1 -> err=1 after 8 stalled cycles, so=11.
//    fs ignored afterwards; rst=0 clears err.
//  5 rst=0 asserted during CMD5 -> all outputs 0 immediately.
//    Next fs sends a complete 12-byte frame with correct checksum.
//  6 Change payload inputs one cycle after fs -> frame carries the old values.
//    fs kept high after fd -> no second frame until fs drops and rises again.

Source files
------------

// File: rtl/cs2fifoc_if.sv
// Command-frame transmitter bus: request/done handshake,
// command FIFO write port, payload bytes and status.
interface cs2fifoc_if;
  logic       fs;
  logic       fd;
  logic       err;
  logic [7:0] so;
  logic       fifoc_full;
  logic       fifoc_txen;
  logic [7:0] fifoc_txd;
  logic [7:0] kind_dev;
  logic [7:0] info_sr;
  logic [7:0] cmd_filt;
  logic [7:0] cmd_mix0;
  logic [7:0] cmd_reg4;
  logic [7:0] cmd_reg5;
  logic [7:0] cmd_reg6;
  logic [7:0] cmd_reg7;
  logic [7:0] cmd_mix1;

  modport master (
    output fs, fifoc_full,
    output kind_dev, info_sr, cmd_filt,
    output cmd_mix0, cmd_reg4, cmd_reg5,
    output cmd_reg6, cmd_reg7, cmd_mix1,
    input  fd, err, so,
    input  fifoc_txen, fifoc_txd
  );

  modport slave (
    input  fs, fifoc_full,
    input  kind_dev, info_sr, cmd_filt,
    input  cmd_mix0, cmd_reg4, cmd_reg5,
    input  cmd_reg6, cmd_reg7, cmd_mix1,
    output fd, err, so,
    output fifoc_txen, fifoc_txd
  );
endinterface

// File: rtl/cs2fifoc.sv
// Command-frame transmitter: 55 AA, nine snapshot
// bytes and an 8-bit sum, written into the command FIFO.
module cs2fifoc #(
  parameter logic [7:0]      HEAD0   = 8'h55,
  parameter logic [7:0]      HEAD1   = 8'hAA,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'd1000
) (
  input logic        clk,
  input logic        rst,
  cs2fifoc_if.slave  bus
);

  typedef enum logic [7:0] {
    IDLE = 8'h00,
    HED0 = 8'h03,
    HED1 = 8'h04,
    CMD0 = 8'h05,
    CMD1 = 8'h06,
    CMD2 = 8'h07,
    CMD3 = 8'h08,
    CMD4 = 8'h09,
    CMD5 = 8'h0A,
    CMD6 = 8'h0B,
    CMD7 = 8'h0C,
    CMD8 = 8'h0D,
    PART = 8'h0E,
    LAST = 8'h0F,
    ERR  = 8'h11
  } state_t;

  state_t          state;
  logic [7:0]      snap [9];
  logic [7:0]      check;
  logic [7:0]      txd;
  logic            txen;
  logic            err;
  logic [TO_W-1:0] stall;

  logic            emit;
  logic            is_cmd;
  logic [3:0]      idx;
  logic [7:0]      tx_byte;

  always_comb begin
    is_cmd  = (state >= CMD0) && (state <= CMD8);
    emit    = (state >= HED0) && (state <= PART);
    idx     = 4'(state - CMD0);
    tx_byte = '0;
    unique case (1'b1)
      state == HED0: tx_byte = HEAD0;
      state == HED1: tx_byte = HEAD1;
      is_cmd:        tx_byte = snap[idx];
      state == PART: tx_byte = check;
      default:       tx_byte = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      txen  <= 1'b0;
      txd   <= '0;
      err   <= 1'b0;
      check <= '0;
      stall <= '0;
      snap  <= '{default: '0};
    end else begin
      txen <= 1'b0;
      unique case (1'b1)
        state == IDLE: begin
          stall <= '0;
          if (bus.fs) begin
            snap[0] <= bus.kind_dev;
            snap[1] <= bus.info_sr;
            snap[2] <= bus.cmd_filt;
            snap[3] <= bus.cmd_mix0;
            snap[4] <= bus.cmd_reg4;
            snap[5] <= bus.cmd_reg5;
            snap[6] <= bus.cmd_reg6;
            snap[7] <= bus.cmd_reg7;
            snap[8] <= bus.cmd_mix1;
            check   <= '0;
            state   <= HED0;
          end
        end
        emit: begin
          // emit codes are contiguous, PART+1 is LAST
          if (!bus.fifoc_full) begin
            txen  <= 1'b1;
            txd   <= tx_byte;
            stall <= '0;
            state <= state_t'(state + 8'd1);
            if (state == CMD0)
              check <= tx_byte;
            else if (is_cmd)
              check <= check + tx_byte;
          end else if (stall == TIMEOUT - TO_W'(1)) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            stall <= stall + TO_W'(1);
          end
        end
        state == LAST: begin
          if (!bus.fs)
            state <= IDLE;
        end
        default: begin
          err <= 1'b1;
        end
      endcase
    end
  end

  assign bus.fifoc_txen = txen;
  assign bus.fifoc_txd  = txd;
  assign bus.err        = err;
  assign bus.so         = state;
  assign bus.fd         = (state == LAST);

endmodule
